// File: rtl/new_packer.sv
// new_packer -- width-up byte packer for the write-back path.
//
// Packs IN_WIDTH result words into OUT_WIDTH stream words, byte-contiguous
// and little-endian (byte 0 of the first input word lands in lane 0).
// Residue bytes carry over between output words, and a flush drains a final
// partial word with a byte-keep mask and a last flag.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   din/din_valid/din_ready    narrow input beat (transfers on valid & ready)
//   flush                      single-cycle end-of-stream request
//   flush_busy                 high while a requested drain is in progress
//   dout/dout_keep/dout_last   packed output word, lane mask, end of stream
//   dout_valid/dout_ready      output handshake
module new_packer #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_WIDTH-1:0]    din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic                   flush,
  output logic                   flush_busy,
  output logic [OUT_WIDTH-1:0]   dout,
  output logic [OUT_WIDTH/8-1:0] dout_keep,
  output logic                   dout_last,
  output logic                   dout_valid,
  input  logic                   dout_ready
);

  localparam int IN_B  = IN_WIDTH / 8;
  localparam int OUT_B = OUT_WIDTH / 8;
  localparam int ACC_B = OUT_B + IN_B - 1;
  localparam int ACC_W = ACC_B * 8;
  localparam int CNT_W = $clog2(ACC_B + 1);

  localparam logic [CNT_W-1:0] IN_B_C  = CNT_W'(IN_B);
  localparam logic [CNT_W-1:0] OUT_B_C = CNT_W'(OUT_B);

  // Accumulator bytes at or above fill are always zero. That lets a new beat
  // be OR-ed in at its byte offset and makes a partial word zero-padded for
  // free.
  logic [ACC_W-1:0]     acc_q,   acc_d;
  logic [CNT_W-1:0]     fill_q,  fill_d;
  logic                 pend_q,  pend_d;
  logic [OUT_WIDTH-1:0] dout_q,  dout_d;
  logic [OUT_B-1:0]     keep_q,  keep_d;
  logic                 last_q,  last_d;
  logic                 valid_q, valid_d;

  logic                 out_free;
  logic                 xfer_full;
  logic                 xfer_part;
  logic                 accept;
  logic [CNT_W-1:0]     wr_base;
  logic [OUT_B-1:0]     keep_part;

  // Handshake decode. din_ready looks at dout_ready through xfer_full so a
  // full word can leave while the next beat arrives, keeping one beat/cycle.
  always_comb begin
    out_free  = !valid_q || dout_ready;
    xfer_full = (fill_q >= OUT_B_C) && out_free;
    xfer_part = pend_q && (fill_q != '0) && (fill_q < OUT_B_C) && out_free;
    din_ready = !pend_q && ((fill_q < OUT_B_C) || xfer_full);
    accept    = din_valid && din_ready;
  end

  // Accumulator and fill count.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves one unassigned and no latch is inferred.
    acc_d   = acc_q;
    fill_d  = fill_q;
    wr_base = fill_q;
    if (xfer_full) begin
      acc_d   = acc_q >> OUT_WIDTH;
      fill_d  = fill_q - OUT_B_C;
      wr_base = fill_q - OUT_B_C;
    end
    if (xfer_part) begin
      acc_d  = '0;
      fill_d = '0;
    end
    if (accept) begin
      acc_d  = acc_d | (ACC_W'(din) << {wr_base, 3'b000});
      fill_d = fill_d + IN_B_C;
    end
  end

  // Lane mask for a flushed partial word: lanes below fill hold data.
  always_comb begin
    keep_part = '0;
    for (int i = 0; i < OUT_B; i++) begin
      keep_part[i] = (CNT_W'(i) < fill_q);
    end
  end

  // Output register; holds until accepted.
  always_comb begin
    dout_d  = dout_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (xfer_full) begin
      dout_d  = acc_q[OUT_WIDTH-1:0];
      keep_d  = '1;
      // A full word is last only when it exactly empties a flushed stream.
      last_d  = pend_q && (fill_q == OUT_B_C);
      valid_d = 1'b1;
    end else if (xfer_part) begin
      dout_d  = acc_q[OUT_WIDTH-1:0];
      keep_d  = keep_part;
      last_d  = 1'b1;
      valid_d = 1'b1;
    end else if (dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // Flush tracking: armed by flush, cleared once the accumulator is empty
  // and the output register can take a word (so the final word has left).
  always_comb begin
    pend_d = pend_q;
    if (!pend_q && flush) begin
      pend_d = 1'b1;
    end else if (pend_q && (fill_q == '0) && out_free) begin
      pend_d = 1'b0;
    end
  end

  // NOTE: the accumulator is reset along with the control state; a reset
  // mid-stream must discard held bytes and restore the zero-above-fill rule.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      acc_q   <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      dout_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_keep  = keep_q;
  assign dout_last  = last_q;
  assign dout_valid = valid_q;
  assign flush_busy = pend_q;

endmodule

// File: tb/tb_new_packer.sv
// Testbench for new_packer: default 128->512 instance checked against a
// byte-queue reference model, plus a 96->512 instance for residue carry.
module tb_new_packer;

  localparam int IN_B  = 16;
  localparam int OUT_B = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         flush;
  logic         flush_busy;
  logic [511:0] dout;
  logic [63:0]  dout_keep;
  logic         dout_last;
  logic         dout_valid;
  logic         dout_ready;

  logic         b_rst;
  logic [95:0]  b_din;
  logic         b_din_valid;
  logic         b_din_ready;
  logic         b_flush;
  logic         b_flush_busy;
  logic [511:0] b_dout;
  logic [63:0]  b_dout_keep;
  logic         b_dout_last;
  logic         b_dout_valid;
  logic         b_dout_ready;

  always #5 clk = ~clk;

  new_packer u_dut (
    .clk(clk), .rst(rst),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .flush(flush), .flush_busy(flush_busy),
    .dout(dout), .dout_keep(dout_keep), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  new_packer #(.IN_WIDTH(96), .OUT_WIDTH(512)) u_dut96 (
    .clk(clk), .rst(b_rst),
    .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .flush(b_flush), .flush_busy(b_flush_busy),
    .dout(b_dout), .dout_keep(b_dout_keep), .dout_last(b_dout_last),
    .dout_valid(b_dout_valid), .dout_ready(b_dout_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (main instance) ----------------
  logic [7:0]   exp_q[$];
  bit           flushed = 1'b0;
  int           n_beats = 0;
  bit           last_seen = 1'b0;
  logic [63:0]  last_keep = '0;
  int           stall_cnt = 0;
  bit           hold_armed = 1'b0;
  logic [511:0] held_dout;
  logic [511:0] m_exp_d;
  logic [63:0]  m_exp_k;
  bit           m_exp_l;
  int           m_n;

  // Stimulus controls.
  int next_byte  = 0;
  bit rand_data  = 1'b0;
  bit rand_valid = 1'b0;
  bit ready_rand = 1'b0;
  bit ready_val  = 1'b1;

  always @(posedge clk) begin
    #2;
    dout_ready = ready_rand ? ($urandom_range(0, 2) != 0) : ready_val;
  end

  // Output beats take the oldest unsent bytes of the stream: a full word
  // when 64 or more remain, otherwise (only after flush) the remainder.
  // A beat is last when a flush is outstanding and it empties the stream.
  always @(negedge clk) begin
    if (rst) begin
      hold_armed = 1'b0;
    end else begin
      if (dout_valid && dout_ready) begin
        m_n     = (exp_q.size() < OUT_B) ? exp_q.size() : OUT_B;
        m_exp_d = '0;
        m_exp_k = '0;
        for (int i = 0; i < m_n; i++) begin
          m_exp_d[8*i +: 8] = exp_q[i];
          m_exp_k[i]        = 1'b1;
        end
        m_exp_l = flushed && (exp_q.size() <= OUT_B);
        check("dout_data", dout, m_exp_d);
        check("dout_keep", 512'(dout_keep), 512'(m_exp_k));
        check("dout_last", 512'(dout_last), 512'(m_exp_l));
        for (int i = 0; i < m_n; i++) void'(exp_q.pop_front());
        if (m_exp_l) flushed = 1'b0;
        n_beats++;
        last_keep = dout_keep;
        last_seen = last_seen | dout_last;
      end
      if (dout_valid && !dout_ready) begin
        if (hold_armed) check("dout_hold", dout, held_dout);
        held_dout  = dout;
        hold_armed = 1'b1;
      end else begin
        hold_armed = 1'b0;
      end
      if (din_valid && din_ready) begin
        for (int b = 0; b < IN_B; b++) exp_q.push_back(din[8*b +: 8]);
      end
      if (flush && !flush_busy) flushed = 1'b1;
    end
  end

  // ---------------- 96-bit instance observer ----------------
  logic [511:0] b_words[4];
  int           b_cnt = 0;
  int           b_busy = 0;
  bit           b_last_seen = 1'b0;
  bit           b_keep_ok = 1'b1;

  always @(negedge clk) begin
    if (!b_rst) begin
      if (b_dout_valid && b_dout_ready) begin
        if (b_cnt < 4) b_words[b_cnt] = b_dout;
        b_cnt++;
        b_last_seen = b_last_seen | b_dout_last;
        b_keep_ok   = b_keep_ok & (b_dout_keep == '1);
      end
      if (b_flush_busy) b_busy++;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [127:0] mk(input int base);
    logic [127:0] w;
    for (int b = 0; b < IN_B; b++) w[8*b +: 8] = rand_data ? 8'($urandom) : 8'(base + b);
    return w;
  endfunction

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input int n);
    int sent = 0;
    int guard = 0;
    logic [127:0] w;
    bit have = 1'b0;
    while (sent < n && guard < 5000) begin
      @(posedge clk); #1;
      if (!have) begin
        w    = mk(next_byte);
        have = 1'b1;
      end
      if (rand_valid && ($urandom_range(0, 3) == 0)) begin
        din_valid = 1'b0;
      end else begin
        din       = w;
        din_valid = 1'b1;
      end
      @(negedge clk);
      if (din_valid && !din_ready) stall_cnt++;
      if (din_valid && din_ready) begin
        sent++;
        next_byte += IN_B;
        have = 1'b0;
      end
      guard++;
    end
    if (sent < n) check("send_budget", 512'(sent), 512'(n));
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic do_flush();
    int busy_bad = 0;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!flush_busy) break;
      if (din_ready) busy_bad++;
    end
    check("flush_drain_done", 512'(flush_busy), 512'(0));
    check("din_ready_low_while_busy", 512'(busy_bad), 512'(0));
  endtask

  typedef struct {
    int          nbeats;
    bit          do_flush;
    int          exp_beats;
    logic [63:0] exp_keep;
    bit          exp_last;
  } row_t;

  row_t rows[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] exp_w;

    rows[0] = '{8, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    rows[1] = '{5, 1'b1, 2, 64'h0000_0000_0000_FFFF, 1'b1};
    rows[2] = '{4, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    rows[3] = '{1, 1'b1, 1, 64'h0000_0000_0000_FFFF, 1'b1};
    rows[4] = '{7, 1'b1, 2, 64'h0000_FFFF_FFFF_FFFF, 1'b1};

    rst = 1'b1; din = '0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b1;
    b_rst = 1'b1; b_din = '0; b_din_valid = 1'b0; b_flush = 1'b0; b_dout_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout_valid", 512'(dout_valid), 512'(0));
    check("rst_dout", dout, 512'(0));
    check("rst_dout_keep", 512'(dout_keep), 512'(0));
    check("rst_dout_last", 512'(dout_last), 512'(0));
    check("rst_flush_busy", 512'(flush_busy), 512'(0));
    check("rst_din_ready", 512'(din_ready), 512'(1));

    // Table: incrementing bytes, downstream always ready, optional flush
    // after the stream has gone idle.
    for (int r = 0; r < 5; r++) begin
      next_byte = 0; rand_data = 1'b0; rand_valid = 1'b0;
      ready_rand = 1'b0; ready_val = 1'b1;
      n_beats = 0; last_seen = 1'b0; last_keep = '0; stall_cnt = 0;
      send(rows[r].nbeats);
      idle(4);
      if (rows[r].do_flush) begin
        do_flush();
        idle(4);
      end
      flushed = 1'b0;
      check($sformatf("row%0d_beats", r), 512'(n_beats), 512'(rows[r].exp_beats));
      check($sformatf("row%0d_final_keep", r), 512'(last_keep), 512'(rows[r].exp_keep));
      check($sformatf("row%0d_last", r), 512'(last_seen), 512'(rows[r].exp_last));
      check($sformatf("row%0d_din_ready_stalls", r), 512'(stall_cnt), 512'(0));
      check($sformatf("row%0d_bytes_left", r), 512'(exp_q.size()), 512'(0));
    end

    // Backpressure: downstream stalls 10 cycles during a continuous stream.
    next_byte = 0; n_beats = 0; stall_cnt = 0;
    fork
      send(12);
      begin
        repeat (3) @(posedge clk);
        #1 ready_val = 1'b0;
        repeat (10) @(posedge clk);
        #1 ready_val = 1'b1;
      end
    join
    idle(6);
    check("bp_din_ready_fell", 512'(stall_cnt > 0), 512'(1));
    check("bp_beats", 512'(n_beats), 512'(3));
    check("bp_bytes_left", 512'(exp_q.size()), 512'(0));

    // Flush in the same cycle as the beat that brings the stream to 64
    // bytes, held two more cycles while busy.
    next_byte = 0; n_beats = 0; last_seen = 1'b0; last_keep = '0;
    send(3);
    din = mk(next_byte); din_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("f4_din_ready", 512'(din_ready), 512'(1));
    next_byte += IN_B;
    @(posedge clk); #1 din_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b0;
    idle(6);
    check("f4_beats", 512'(n_beats), 512'(1));
    check("f4_keep", 512'(last_keep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    check("f4_last", 512'(last_seen), 512'(1));
    check("f4_busy_cleared", 512'(flush_busy), 512'(0));
    check("f4_bytes_left", 512'(exp_q.size()), 512'(0));
    flushed = 1'b0;

    // Reset mid-stream with 48 bytes held, then restart from lane 0.
    next_byte = 0; n_beats = 0;
    send(3);
    rst = 1'b1;
    exp_q.delete();
    flushed = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_dout_valid", 512'(dout_valid), 512'(0));
    check("mrst_din_ready", 512'(din_ready), 512'(1));
    check("mrst_flush_busy", 512'(flush_busy), 512'(0));
    next_byte = 8'h80;
    send(4);
    idle(4);
    check("mrst_beats", 512'(n_beats), 512'(1));
    check("mrst_bytes_left", 512'(exp_q.size()), 512'(0));

    // Randomized rounds: random data, valid gaps and downstream stalls.
    for (int rnd = 0; rnd < 4; rnd++) begin
      rand_data = 1'b1; rand_valid = 1'b1; ready_rand = 1'b1;
      send($urandom_range(20, 60));
      ready_rand = 1'b0; ready_val = 1'b1; rand_valid = 1'b0;
      idle(6);
      do_flush();
      idle(4);
      check($sformatf("rand%0d_bytes_left", rnd), 512'(exp_q.size()), 512'(0));
      flushed = 1'b0;
    end
    rand_data = 1'b0;

    // 96-bit input: 16 beats (192 bytes) then flush with nothing held.
    @(posedge clk); #1 b_rst = 1'b0;
    begin
      int b_stall = 0;
      for (int k = 0; k < 16; k++) begin
        for (int j = 0; j < 12; j++) b_din[8*j +: 8] = 8'(12*k + j);
        b_din_valid = 1'b1;
        @(negedge clk);
        if (!b_din_ready) b_stall++;
        @(posedge clk); #1;
      end
      b_din_valid = 1'b0;
      check("w96_din_ready_stalls", 512'(b_stall), 512'(0));
    end
    idle(3);
    b_flush = 1'b1;
    @(posedge clk); #1 b_flush = 1'b0;
    idle(6);
    check("w96_beats", 512'(b_cnt), 512'(3));
    for (int w = 0; w < 3; w++) begin
      for (int j = 0; j < OUT_B; j++) exp_w[8*j +: 8] = 8'(64*w + j);
      check($sformatf("w96_word%0d", w), b_words[w], exp_w);
    end
    check("w96_keep_full", 512'(b_keep_ok), 512'(1));
    check("w96_busy_cycles", 512'(b_busy), 512'(1));
    check("w96_no_last", 512'(b_last_seen), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
